// File: rtl/des_key_schedule_seq.sv
// Sequential DES key schedule: PC-1 load, one C/D rotation per round, and
// PC-2 subkeys on a valid/ready stream in K1..K16 or K16..K1 order.
module des_key_schedule_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:64] key_in,
    input  logic        key_valid,
    input  logic        decrypt,
    output logic        key_ready,
    output logic [1:48] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        last
);
    typedef enum logic {IDLE, GEN} stateT;

    localparam int unsigned PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int unsigned PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    // Bit i set means round i+1 rotates by one position; all others rotate by two.
    localparam logic [15:0] ONE_SHIFT = 16'b1000_0001_0000_0011;

    function automatic logic [1:56] pc1(input logic [1:64] k);
        logic [1:56] res;
        for (int unsigned i = 0; i < 56; i++) res[i+1] = k[PC1[i]];
        return res;
    endfunction

    function automatic logic [1:48] pc2(input logic [1:56] cd);
        logic [1:48] res;
        for (int unsigned i = 0; i < 48; i++) res[i+1] = cd[PC2[i]];
        return res;
    endfunction

    function automatic logic [1:28] rot(input logic [1:28] h, input logic right, input logic two);
        logic [1:28] res;
        case ({right, two})
            2'b00:   res = {h[2:28], h[1]};
            2'b01:   res = {h[3:28], h[1:2]};
            2'b10:   res = {h[28], h[1:27]};
            default: res = {h[27:28], h[1:26]};
        endcase
        return res;
    endfunction

    stateT       state, nextState;
    logic [1:28] c, d, nextC, nextD;
    logic [4:0]  roundCnt, nextRound;
    logic        mode, nextMode;
    logic [1:56] loadCd;
    logic [3:0]  shiftSel;
    logic        twoStep;
    logic        unusedParity;

    // Parity bits take no part in the schedule.
    assign unusedParity = ^{key_in[8], key_in[16], key_in[24], key_in[32],
                            key_in[40], key_in[48], key_in[56], key_in[64]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            c        <= '0;
            d        <= '0;
            roundCnt <= '0;
            mode     <= 1'b0;
        end else begin
            state    <= nextState;
            c        <= nextC;
            d        <= nextD;
            roundCnt <= nextRound;
            mode     <= nextMode;
        end
    end

    always_comb begin
        nextState = state;
        nextC     = c;
        nextD     = d;
        nextRound = roundCnt;
        nextMode  = mode;
        loadCd    = pc1(key_in);
        // Encrypt uses shift[r+1], decrypt uses shift[17-r]; both as 0-based mask bits.
        shiftSel  = mode ? 4'(5'd16 - roundCnt) : roundCnt[3:0];
        twoStep   = ~ONE_SHIFT[shiftSel];
        unique case (state)
            IDLE: begin
                if (key_valid) begin
                    nextState = GEN;
                    nextRound = 5'd1;
                    nextMode  = decrypt;
                    if (decrypt) begin
                        nextC = loadCd[1:28];
                        nextD = loadCd[29:56];
                    end else begin
                        nextC = rot(loadCd[1:28], 1'b0, 1'b0);
                        nextD = rot(loadCd[29:56], 1'b0, 1'b0);
                    end
                end
            end
            GEN: begin
                if (subkey_ready) begin
                    if (roundCnt == 5'd16) begin
                        nextState = IDLE;
                        nextRound = '0;
                    end else begin
                        nextC     = rot(c, mode, twoStep);
                        nextD     = rot(d, mode, twoStep);
                        nextRound = roundCnt + 5'd1;
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign key_ready    = (state == IDLE);
    assign subkey_valid = (state == GEN);
    assign subkey       = pc2({c, d});
    // Round 16 wraps to 0 on the 4-bit port; last identifies it.
    assign round        = roundCnt[3:0];
    assign last         = subkey_valid && (roundCnt == 5'd16);

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Scoreboard bench for des_key_schedule_seq using the FIPS 46-3 worked-example key.
module tb_des_key_schedule_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] key_in = '0;
    logic        key_valid = 1'b0;
    logic        decrypt = 1'b0;
    logic        key_ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready = 1'b1;
    logic [3:0]  round;
    logic        last;

    des_key_schedule_seq dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_in       (key_in),
        .key_valid    (key_valid),
        .decrypt      (decrypt),
        .key_ready    (key_ready),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round        (round),
        .last         (last)
    );

    typedef struct { logic [47:0] key; int unsigned rnd; } expT;
    expT sbQ [$];
    int  errors = 0;
    int  checks = 0;
    logic readyRandom = 1'b0;

    localparam logic [47:0] ENC_K [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_P = 64'h123556789ABDDEF0;  // KEY_A with every parity bit flipped

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge T.
    task automatic issueKey(input logic [63:0] k, input logic dec);
        int unsigned w = 0;
        expT e;
        while (!key_ready && w < 1000) begin
            @(posedge clk); #1; w++;
        end
        if (!key_ready) begin
            checks++; errors++;
            $display("FAIL key_ready wait: got 0 expected 1");
        end
        for (int unsigned r = 1; r <= 16; r++) begin
            e.key = dec ? ENC_K[16 - r] : ENC_K[r - 1];
            e.rnd = r;
            sbQ.push_back(e);
        end
        key_in = k; decrypt = dec; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    // Counts edges after acceptance until idle; 16 edges means key_ready in cycle T+17.
    task automatic waitIdle(input bit checkLat, input string name);
        int unsigned n = 0;
        while (!key_ready && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        if (!key_ready) begin
            checks++; errors++;
            $display("FAIL %s: key_ready got 0 expected 1", name);
        end else if (checkLat) begin
            check(name, 64'(n), 64'd16);
        end
    endtask

    initial forever begin
        @(posedge clk); #1;
        subkey_ready = readyRandom ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: pop on every handshake, and verify outputs hold across stalls.
    initial begin
        logic        holdPending;
        logic [47:0] holdKey;
        logic [3:0]  holdRound;
        expT         e;
        holdPending = 1'b0;
        holdKey = '0;
        holdRound = '0;
        forever begin
            @(negedge clk);
            if (holdPending) begin
                check("stall valid", 64'(subkey_valid), 64'd1);
                check("stall subkey", 64'(subkey), 64'(holdKey));
                check("stall round", 64'(round), 64'(holdRound));
            end
            holdPending = subkey_valid && !subkey_ready;
            holdKey = subkey;
            holdRound = round;
            if (subkey_valid && subkey_ready) begin
                if (sbQ.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected subkey: got %0h expected none", subkey);
                end else begin
                    e = sbQ.pop_front();
                    check("subkey", 64'(subkey), 64'(e.key));
                    check("round", 64'(round), 64'(4'(e.rnd)));
                    check("last", 64'(last), 64'(e.rnd == 16));
                end
            end
        end
    end

    initial begin
        #1;
        check("reset key_ready", 64'(key_ready), 64'd1);
        check("reset subkey_valid", 64'(subkey_valid), 64'd0);
        check("reset round", 64'(round), 64'd0);
        check("reset last", 64'(last), 64'd0);
        check("reset subkey", 64'(subkey), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Encrypt, then decrypt with the parity-flipped key accepted at T+17.
        issueKey(KEY_A, 1'b0);
        check("enc first valid", 64'(subkey_valid), 64'd1);
        check("enc first round", 64'(round), 64'd1);
        waitIdle(1'b1, "enc key_ready latency");
        issueKey(KEY_P, 1'b1);
        check("b2b first valid", 64'(subkey_valid), 64'd1);
        check("b2b first subkey", 64'(subkey), 64'hCB3D8B0E17F5);
        waitIdle(1'b1, "dec key_ready latency");

        issueKey(KEY_A, 1'b1);
        waitIdle(1'b1, "dec2 key_ready latency");
        issueKey(KEY_P, 1'b0);
        waitIdle(1'b1, "parity key_ready latency");

        // Random backpressure with a stray key pulse mid-sequence.
        readyRandom = 1'b1;
        issueKey(KEY_A, 1'b0);
        repeat (5) begin @(posedge clk); #1; end
        key_in = ~KEY_A; decrypt = 1'b1; key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        waitIdle(1'b0, "stall idle");
        readyRandom = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Asynchronous reset while round 7 is presented.
        issueKey(KEY_A, 1'b0);
        repeat (6) begin @(posedge clk); #1; end
        check("abort pre round", 64'(round), 64'd7);
        #2 reset_n = 1'b0;
        #1;
        check("abort subkey_valid", 64'(subkey_valid), 64'd0);
        check("abort round", 64'(round), 64'd0);
        check("abort key_ready", 64'(key_ready), 64'd1);
        check("abort last", 64'(last), 64'd0);
        check("abort consumed", 64'(sbQ.size()), 64'd10);
        sbQ.delete();
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        issueKey(KEY_A, 1'b0);
        check("restart round", 64'(round), 64'd1);
        waitIdle(1'b1, "restart key_ready latency");

        repeat (2) begin @(posedge clk); #1; end
        check("scoreboard drained", 64'(sbQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
